// File: rtl/raven_arb_pkg.sv
// Shared constants and state type for the 16-way round-robin arbiter.
package raven_arb_pkg;

   localparam int unsigned NUM_REQ = 16;
   localparam int unsigned IDX_W   = 4;

   typedef enum logic [0:0] {IDLE, GRANT} arb_state_e;

endpackage

// File: rtl/priority_enc_16.sv
// 16-bit priority encoder: highest set bit, returned as index+1 (0 when no bit is set).
module priority_enc_16 (
   input  logic [15:0] req,
   output logic [4:0]  enc
);

   always_comb begin
      enc = 5'd0;
      for (int i = 0; i < 16; i++) begin
         if (req[i]) enc = 5'(i + 1);
      end
   end

endmodule

// File: rtl/rr_arb_16.sv
// Round-robin arbiter for 16 requesters with owner release, request-drop release and hold timeout.
// All outputs are registered; priority rotates downward from the last granted index.
module rr_arb_16
   import raven_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic               timeout
);

   localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   arb_state_e         state;
   logic [IDX_W-1:0]   last_idx;
   logic [CNT_W-1:0]   hold_cnt;

   logic [NUM_REQ-1:0] mask;
   logic [IDX_W:0]     enc_masked;
   logic [IDX_W:0]     enc_full;
   logic [IDX_W:0]     enc_sel;
   logic [IDX_W:0]     enc_sel_m1;
   logic [IDX_W-1:0]   winner;
   logic               owner_req;
   logic               hold_exp;
   logic               release_now;

   // Bits strictly below the last winner take precedence, giving the downward rotation.
   assign mask = req & ((NUM_REQ'(1) << last_idx) - NUM_REQ'(1));

   priority_enc_16 u_enc_masked (
      .req (mask),
      .enc (enc_masked)
   );

   priority_enc_16 u_enc_full (
      .req (req),
      .enc (enc_full)
   );

   assign enc_sel     = (enc_masked != '0) ? enc_masked : enc_full;
   assign enc_sel_m1  = enc_sel - 1'b1;
   assign winner      = enc_sel_m1[IDX_W-1:0];

   assign owner_req   = req[gnt_idx];
   assign hold_exp    = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
   assign release_now = done || !owner_req || hold_exp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt_valid  <= 1'b0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         timeout    <= 1'b0;
         last_idx   <= '0;
         hold_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (req != '0) begin
                  state      <= GRANT;
                  gnt_valid  <= 1'b1;
                  gnt_idx    <= winner;
                  gnt_onehot <= NUM_REQ'(1) << winner;
                  last_idx   <= winner;
                  hold_cnt   <= CNT_W'(1);
               end
            end
            GRANT: begin
               if (release_now) begin
                  state      <= IDLE;
                  gnt_valid  <= 1'b0;
                  gnt_idx    <= '0;
                  gnt_onehot <= '0;
                  // Flag only revocations where the timer was the sole cause.
                  timeout    <= hold_exp && !done && owner_req;
               end else begin
                  timeout <= 1'b0;
                  if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb_16.sv
// Randomized and directed bench for rr_arb_16 against a priority-list reference model.
module tb_rr_arb_16;

   localparam int MAXH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic        gnt_valid;
   logic [3:0]  gnt_idx;
   logic [15:0] gnt_onehot;
   logic        timeout;

   int tests = 0;
   int fails = 0;

   // Reference model: owner/priority described directly, not by encoder or mask.
   bit m_valid;
   int m_idx;
   int m_last;
   int m_held;
   bit m_timeout;
   int grants[$];

   rr_arb_16 #(.MAX_HOLD(MAXH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .done       (done),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_idx = 0; m_last = 0; m_held = 0; m_timeout = 0;
   endtask

   task automatic model_step(input logic [15:0] r, input logic d);
      if (!m_valid) begin
         m_timeout = 0;
         // Walk priority list last-1, last-2, ..., wrapping down to last itself.
         for (int k = 1; k <= 16; k++) begin
            int c;
            c = (m_last - k + 32) % 16;
            if (r[c]) begin
               m_valid = 1; m_idx = c; m_last = c; m_held = 1;
               grants.push_back(c);
               break;
            end
         end
      end else begin
         bit expired;
         expired = (MAXH != 0) && (m_held >= MAXH);
         if (d || !r[m_idx] || expired) begin
            m_timeout = expired && !d && r[m_idx];
            m_valid = 0; m_idx = 0;
         end else begin
            m_timeout = 0;
            m_held++;
         end
      end
   endtask

   task automatic compare_outputs();
      logic [15:0] oh;
      oh = m_valid ? (16'd1 << m_idx) : 16'd0;
      check("gnt_valid", 32'(gnt_valid), 32'(m_valid));
      check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      check("gnt_onehot", 32'(gnt_onehot), 32'(oh));
      check("timeout", 32'(timeout), 32'(m_timeout));
   endtask

   task automatic cycle(input logic [15:0] r, input logic d);
      @(negedge clk);
      req = r; done = d;
      @(posedge clk);
      model_step(r, d);
      #1 compare_outputs();
   endtask

   task automatic go_idle();
      cycle(16'h0000, 1'b0);
      cycle(16'h0000, 1'b0);
   endtask

   initial begin
      int vcnt;
      int tcnt;
      model_reset();
      #12 rst_n = 1'b1;
      #1 compare_outputs();

      // Idle with no requests.
      for (int i = 0; i < 5; i++) cycle(16'h0000, 1'b0);

      // Two requesters, owner releases on its first granted cycle.
      grants.delete();
      for (int i = 0; i < 8; i++) cycle(16'h8001, m_valid);
      check("order_8001_len", 32'(grants.size()), 32'd4);
      if (grants.size() >= 4) begin
         check("order_8001_0", 32'(grants[0]), 32'd15);
         check("order_8001_1", 32'(grants[1]), 32'd0);
         check("order_8001_2", 32'(grants[2]), 32'd15);
         check("order_8001_3", 32'(grants[3]), 32'd0);
      end
      go_idle();

      // Three requesters, owner releases after holding two cycles.
      model_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      grants.delete();
      for (int i = 0; i < 12; i++) cycle(16'h0124, m_valid && m_held >= 2);
      check("order_0124_len", 32'(grants.size()), 32'd4);
      if (grants.size() >= 4) begin
         check("order_0124_0", 32'(grants[0]), 32'd8);
         check("order_0124_1", 32'(grants[1]), 32'd5);
         check("order_0124_2", 32'(grants[2]), 32'd2);
         check("order_0124_3", 32'(grants[3]), 32'd8);
      end
      go_idle();

      // Hold timeout: single requester never releases.
      vcnt = 0; tcnt = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(16'h0010, 1'b0);
         vcnt += int'(gnt_valid);
         tcnt += int'(timeout);
      end
      check("hold_valid_cycles", 32'(vcnt), 32'(MAXH));
      check("hold_timeout_pulses", 32'(tcnt), 32'd1);
      check("hold_timeout_at_fall", {31'd0, timeout & ~gnt_valid}, 32'd1);
      cycle(16'h0010, 1'b0);
      check("regrant_valid", 32'(gnt_valid), 32'd1);
      check("regrant_idx", 32'(gnt_idx), 32'd4);
      go_idle();

      // Owner 3 drops request while 7 rises: wrap past 0 to 7.
      grants.delete();
      cycle(16'h0008, 1'b0);
      cycle(16'h0080, 1'b0);
      check("drop_release_valid", 32'(gnt_valid), 32'd0);
      check("drop_release_timeout", 32'(timeout), 32'd0);
      cycle(16'h0080, 1'b0);
      check("wrap_idx", 32'(gnt_idx), 32'd7);
      check("wrap_valid", 32'(gnt_valid), 32'd1);
      go_idle();

      // Asynchronous reset mid-grant.
      cycle(16'h0200, 1'b0);
      check("pre_reset_idx", 32'(gnt_idx), 32'd9);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(gnt_valid), 32'd0);
      check("async_rst_idx", 32'(gnt_idx), 32'd0);
      check("async_rst_onehot", 32'(gnt_onehot), 32'd0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      req = 16'h0204;
      cycle(16'h0204, 1'b0);
      check("post_reset_first", 32'(gnt_idx), 32'd9);
      go_idle();

      // Random traffic with mixed request density and random releases.
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] r;
         r = 16'($urandom);
         case ($urandom_range(0, 3))
            0: r = r & 16'($urandom);
            1: r = r & 16'($urandom) & 16'($urandom);
            2: r = 16'd1 << $urandom_range(0, 15);
            default: ;
         endcase
         if ($urandom_range(0, 9) == 0) r = '0;
         cycle(r, 1'($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
